// File: rtl/sub32_serial.sv
// sub32_serial: multi-cycle two's-complement subtractor.
// Computes d = a - b as a + ~b + 1, one 4-bit nibble per clock (LSB nibble
// first), with the carry rippled between nibbles through a register.
// co is the final carry out; ov is the carry into the MSB XOR the carry out.
module sub32_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             co,
    output logic             borrow,
    output logic             ov,
    output logic             z,
    output logic             n
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_reg;     // minuend, shifted right one nibble per RUN cycle
    logic [WIDTH-1:0] b_reg;     // complemented subtrahend, shifted alongside a_reg
    logic [WIDTH-1:0] res_reg;   // partial difference, filled from the top nibble down
    logic             carry;     // carry into the nibble currently being processed
    logic [CW-1:0]    count;     // index of the nibble currently being processed

    logic [4:0]       s5;        // nibble sum with carry out in bit 4
    logic [3:0]       s3;        // low three bits plus carry; bit 3 is carry into bit 3
    logic             c3;
    logic             last_nib;
    logic [WIDTH-1:0] d_next;

    // Nibble adder: this cycle's 4-bit slice plus the carry into bit 3.
    always_comb begin
        s5       = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0, carry};
        s3       = {1'b0, a_reg[2:0]} + {1'b0, b_reg[2:0]} + {3'b0, carry};
        c3       = s3[3];
        last_nib = (count == LAST_NIB);
        d_next   = {s5[3:0], res_reg[WIDTH-1:4]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start is honoured only from IDLE.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on start, process one nibble per RUN cycle,
    // and load the visible result and flags with the last nibble so they are
    // valid throughout FIN and hold until the next operation completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            count   <= '0;
            d       <= '0;
            co      <= 1'b0;
            borrow  <= 1'b0;
            ov      <= 1'b0;
            z       <= 1'b0;
            n       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_reg <= a;
                b_reg <= ~b;
                carry <= 1'b1;
                count <= '0;
            end else if (state == RUN) begin
                a_reg   <= {4'b0, a_reg[WIDTH-1:4]};
                b_reg   <= {4'b0, b_reg[WIDTH-1:4]};
                res_reg <= d_next;
                carry   <= s5[4];
                count   <= count + CW'(1);
                if (last_nib) begin
                    d      <= d_next;
                    co     <= s5[4];
                    borrow <= ~s5[4];
                    ov     <= c3 ^ s5[4];
                    z      <= (d_next == '0);
                    n      <= d_next[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// tb_sub32_serial: directed self-checking bench for sub32_serial.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_sub32_serial;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             co;
    logic             borrow;
    logic             ov;
    logic             z;
    logic             n;

    int checks = 0;
    int errors = 0;

    sub32_serial #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .co     (co),
        .borrow (borrow),
        .ov     (ov),
        .z      (z),
        .n      (n)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset state: every output low while reset is held and after release.
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if ({busy, done, co, borrow, ov, z, n} !== 7'b0 || d !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b d=%h co=%b borrow=%b ov=%b z=%b n=%b, required all zero",
                         pass, busy, done, d, co, borrow, ov, z, n);
            end
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
    endtask

    // One subtraction. Operands are scrambled right after the start edge;
    // an optional extra start pulse is driven in cycle inj_k after start.
    task automatic run_op(input string name, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v, input logic [WIDTH-1:0] ed,
                          input logic eco, input logic eov, input logic ez,
                          input logic en, input int inj_k);
        int               done_cnt;
        int               busy_cnt;
        int               done_k;
        logic [WIDTH-1:0] dd;
        logic             dco, dbr, dov, dz, dn, dbusy;
        done_cnt = 0;
        busy_cnt = 0;
        done_k   = 0;
        dd       = '0;
        {dco, dbr, dov, dz, dn, dbusy} = 6'b0;

        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                a = ~ta;
                b = 32'h5A5A_5A5A;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k = k;
                    dd     = d;
                    dco    = co;
                    dbr    = borrow;
                    dov    = ov;
                    dz     = z;
                    dn     = n;
                    dbusy  = busy;
                end
            end
            if (k == inj_k) begin
                a     = 32'h0000_FFFF;
                b     = 32'h0000_0000;
                start = 1'b1;
            end
        end

        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        checks++;
        if (done_k != 9) begin
            errors++;
            $display("FAIL %s done_latency: got cycle %0d, required cycle 9", name, done_k);
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required 8", name, busy_cnt);
        end
        checks++;
        if (dbusy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_fin: got %b, required 0", name, dbusy);
        end
        checks++;
        if (dd !== ed) begin
            errors++;
            $display("FAIL %s d: got %h, required %h", name, dd, ed);
        end
        checks++;
        if ({dco, dbr, dov, dz, dn} !== {eco, ~eco, eov, ez, en}) begin
            errors++;
            $display("FAIL %s flags co/borrow/ov/z/n: got %b%b%b%b%b, required %b%b%b%b%b",
                     name, dco, dbr, dov, dz, dn, eco, ~eco, eov, ez, en);
        end
        checks++;
        if (d !== ed || co !== eco || ov !== eov) begin
            errors++;
            $display("FAIL %s hold: got d=%h co=%b ov=%b, required d=%h co=%b ov=%b",
                     name, d, co, ov, ed, eco, eov);
        end
    endtask

    task automatic test_arith();
        run_op("5-3",         32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op("0-1",         32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_op("3-5",         32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_overflow();
        run_op("min-1",       32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_op("max-neg1",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_zero();
        run_op("equal",       32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    endtask

    // Extra start pulses during RUN and during FIN must be ignored.
    task automatic test_start_ignored();
        run_op("start_in_run", 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        run_op("start_in_fin", 32'h0000_1000, 32'h0000_0FFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 9);
    endtask

    // Asynchronous reset in the middle of RUN aborts with no done pulse.
    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        a     = 32'h0000_0100;
        b     = 32'h0000_0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || d !== '0 || co !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: busy=%b done=%b d=%h co=%b, required 0 0 00000000 0",
                     busy, done, d, co);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles after abort, required 0", done_cnt);
        end
        run_op("9-9_after_abort", 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_overflow();
        test_zero();
        test_start_ignored();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
